mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a one-entry skid buffer, flush, and write-back data selection. It sits between the data-memory stage and register-file write-back. It replaces the plain always-loading MEM/WB register: downstream stalls no longer drop or overwrite results, and branch/exception flushes can squash in-flight entries. Outputs also serve as the WB-stage forwarding source.

---
 rtl/mem_wb_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with valid/ready handshake, a
// one-entry skid buffer and flush.
//
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-high reset
//   valid_in           - upstream entry valid
//   ready_out          - registered "can accept" (low only when both entries are full)
//   flush_in           - squash every held entry; nothing is accepted that cycle
//   write_back_in, mem_to_reg_in, rd_in, read_data_in, address_in
//                      - fields of the incoming entry
//   valid_out          - head entry valid
//   ready_in           - downstream takes the head entry
//   write_back_out, mem_to_reg_out, rd_out, read_data_out, address_out
//                      - fields of the head (MAIN) entry
//   wb_data_out        - selected write-back value of the head entry
//   wb_en_out          - register-file write enable (never for rd = 0)
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  flush_in,
  input  logic                  write_back_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [DATA_W-1:0]     address_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  write_back_out,
  output logic                  mem_to_reg_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     address_out,
  output logic [DATA_W-1:0]     wb_data_out,
  output logic                  wb_en_out
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;

  logic                  main_wb_q, main_wb_d;
  logic                  main_m2r_q, main_m2r_d;
  logic [REG_ADDR_W-1:0] main_rd_q, main_rd_d;
  logic [DATA_W-1:0]     main_rdata_q, main_rdata_d;
  logic [DATA_W-1:0]     main_addr_q, main_addr_d;

  logic                  skid_wb_q, skid_wb_d;
  logic                  skid_m2r_q, skid_m2r_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic [DATA_W-1:0]     skid_rdata_q, skid_rdata_d;
  logic [DATA_W-1:0]     skid_addr_q, skid_addr_d;

  logic                  accept;
  logic                  pop;

  // Flush blocks acceptance even when ready_out is high.
  assign accept = valid_in & ready_q & ~flush_in;
  assign pop    = (state_q != ST_EMPTY) & ready_in;

  always_comb begin
    state_d      = state_q;
    main_wb_d    = main_wb_q;
    main_m2r_d   = main_m2r_q;
    main_rd_d    = main_rd_q;
    main_rdata_d = main_rdata_q;
    main_addr_d  = main_addr_q;
    skid_wb_d    = skid_wb_q;
    skid_m2r_d   = skid_m2r_q;
    skid_rd_d    = skid_rd_q;
    skid_rdata_d = skid_rdata_q;
    skid_addr_d  = skid_addr_q;

    if (flush_in) begin
      // Data fields are left stale; only the control bits matter.
      state_d   = ST_EMPTY;
      main_wb_d = 1'b0;
      skid_wb_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_wb_d    = write_back_in;
            main_m2r_d   = mem_to_reg_in;
            main_rd_d    = rd_in;
            main_rdata_d = read_data_in;
            main_addr_d  = address_in;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_wb_d    = write_back_in;
            main_m2r_d   = mem_to_reg_in;
            main_rd_d    = rd_in;
            main_rdata_d = read_data_in;
            main_addr_d  = address_in;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            // Head is stalled: park the newcomer behind it.
            skid_wb_d    = write_back_in;
            skid_m2r_d   = mem_to_reg_in;
            skid_rd_d    = rd_in;
            skid_rdata_d = read_data_in;
            skid_addr_d  = address_in;
            state_d      = ST_FULL;
          end
        end
        ST_FULL: begin
          // ready_out is low here, so only a pop can change anything.
          if (pop) begin
            main_wb_d    = skid_wb_q;
            main_m2r_d   = skid_m2r_q;
            main_rd_d    = skid_rd_q;
            main_rdata_d = skid_rdata_q;
            main_addr_d  = skid_addr_q;
            state_d      = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      ready_q      <= 1'b1;
      main_wb_q    <= 1'b0;
      main_m2r_q   <= 1'b0;
      main_rd_q    <= '0;
      main_rdata_q <= '0;
      main_addr_q  <= '0;
      skid_wb_q    <= 1'b0;
      skid_m2r_q   <= 1'b0;
      skid_rd_q    <= '0;
      skid_rdata_q <= '0;
      skid_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      main_wb_q    <= main_wb_d;
      main_m2r_q   <= main_m2r_d;
      main_rd_q    <= main_rd_d;
      main_rdata_q <= main_rdata_d;
      main_addr_q  <= main_addr_d;
      skid_wb_q    <= skid_wb_d;
      skid_m2r_q   <= skid_m2r_d;
      skid_rd_q    <= skid_rd_d;
      skid_rdata_q <= skid_rdata_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

  assign ready_out      = ready_q;
  assign valid_out      = (state_q != ST_EMPTY);
  assign write_back_out = main_wb_q;
  assign mem_to_reg_out = main_m2r_q;
  assign rd_out         = main_rd_q;
  assign read_data_out  = main_rdata_q;
  assign address_out    = main_addr_q;
  assign wb_data_out    = main_m2r_q ? main_rdata_q : main_addr_q;
  assign wb_en_out      = valid_out & main_wb_q & (main_rd_q != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage plus a random handshake run against a
// queue scoreboard.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out, flush_in;
  logic        write_back_in, mem_to_reg_in;
  logic [4:0]  rd_in;
  logic [31:0] read_data_in, address_in;
  logic        valid_out, ready_in;
  logic        write_back_out, mem_to_reg_out;
  logic [4:0]  rd_out;
  logic [31:0] read_data_out, address_out, wb_data_out;
  logic        wb_en_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [36:0] sb_q[$];

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_out(ready_out), .flush_in(flush_in),
    .write_back_in(write_back_in), .mem_to_reg_in(mem_to_reg_in),
    .rd_in(rd_in), .read_data_in(read_data_in), .address_in(address_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .write_back_out(write_back_out), .mem_to_reg_out(mem_to_reg_out),
    .rd_out(rd_out), .read_data_out(read_data_out), .address_out(address_out),
    .wb_data_out(wb_data_out), .wb_en_out(wb_en_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic wb, input logic m2r, input logic [4:0] rd,
                     input logic [31:0] rdata, input logic [31:0] addr);
    valid_in      = v;
    write_back_in = wb;
    mem_to_reg_in = m2r;
    rd_in         = rd;
    read_data_in  = rdata;
    address_in    = addr;
  endtask

  initial begin
    rst = 1'b1; flush_in = 1'b0; ready_in = 1'b0;
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick(); tick();

    // Reset state
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_ready_out", {31'b0, ready_out}, 32'd1);
    check("rst_wb_out", {31'b0, write_back_out}, 32'd0);
    check("rst_m2r_out", {31'b0, mem_to_reg_out}, 32'd0);
    check("rst_rd_out", {27'b0, rd_out}, 32'd0);
    check("rst_rdata_out", read_data_out, 32'd0);
    check("rst_addr_out", address_out, 32'd0);
    check("rst_wb_data", wb_data_out, 32'd0);
    check("rst_wb_en", {31'b0, wb_en_out}, 32'd0);
    rst = 1'b0;

    // Streaming: 4 entries back to back, one cycle latency
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 1'b1, 1'b0, 5'(i + 1), 32'hAAAA0000 + 32'(i), 32'h10 + 32'(i));
      tick();
      check("stream_valid", {31'b0, valid_out}, 32'd1);
      check("stream_rd", {27'b0, rd_out}, 32'(i + 1));
      check("stream_wb_data", wb_data_out, 32'h10 + 32'(i));
      check("stream_wb_en", {31'b0, wb_en_out}, 32'd1);
    end
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("stream_drained", {31'b0, valid_out}, 32'd0);

    // Stall / skid: A (rd 5) then B (rd 6) with ready_in low
    ready_in = 1'b0;
    put(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h50);
    tick();
    check("skid_a_rd", {27'b0, rd_out}, 32'd5);
    check("skid_ready_one", {31'b0, ready_out}, 32'd1);
    put(1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 32'h60);
    tick();
    check("skid_a_held", {27'b0, rd_out}, 32'd5);
    check("skid_a_addr_held", address_out, 32'h50);
    check("skid_ready_full", {31'b0, ready_out}, 32'd0);
    // C is offered while FULL and must be ignored
    put(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h70);
    tick();
    check("skid_full_hold", {27'b0, rd_out}, 32'd5);
    check("skid_full_ready", {31'b0, ready_out}, 32'd0);
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ready_in = 1'b1;
    tick();
    check("skid_b_rd", {27'b0, rd_out}, 32'd6);
    check("skid_b_addr", address_out, 32'h60);
    check("skid_ready_back", {31'b0, ready_out}, 32'd1);
    tick();
    check("skid_empty_no_c", {31'b0, valid_out}, 32'd0);

    // Write-back mux and register zero
    ready_in = 1'b0;
    put(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h4);
    tick();
    check("mux_rdata", wb_data_out, 32'hDEADBEEF);
    check("mux_wb_en", {31'b0, wb_en_out}, 32'd1);
    ready_in = 1'b1;
    put(1'b1, 1'b1, 1'b0, 5'd0, 32'h12345678, 32'h8);
    tick();
    check("zero_valid", {31'b0, valid_out}, 32'd1);
    check("zero_rd", {27'b0, rd_out}, 32'd0);
    check("zero_wb_en", {31'b0, wb_en_out}, 32'd0);
    check("zero_wb_data", wb_data_out, 32'h8);
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();

    // Flush while FULL
    ready_in = 1'b0;
    put(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h90);
    tick();
    put(1'b1, 1'b1, 1'b0, 5'd10, 32'h0, 32'hA0);
    tick();
    check("flush_pre_full", {31'b0, ready_out}, 32'd0);
    flush_in = 1'b1;
    put(1'b1, 1'b1, 1'b0, 5'd11, 32'h0, 32'hB0);
    tick();
    flush_in = 1'b0;
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("flush_valid", {31'b0, valid_out}, 32'd0);
    check("flush_ready", {31'b0, ready_out}, 32'd1);
    check("flush_wb_en", {31'b0, wb_en_out}, 32'd0);
    ready_in = 1'b1;
    tick();
    check("flush_no_pop", {31'b0, valid_out}, 32'd0);

    // Flush while ONE with ready_out high: the offered entry is not taken
    ready_in = 1'b0;
    put(1'b1, 1'b1, 1'b0, 5'd12, 32'h0, 32'hC0);
    tick();
    flush_in = 1'b1;
    put(1'b1, 1'b1, 1'b0, 5'd13, 32'h0, 32'hD0);
    tick();
    flush_in = 1'b0;
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("flush_one_valid", {31'b0, valid_out}, 32'd0);
    ready_in = 1'b1;
    tick();
    check("flush_one_no_pop", {31'b0, valid_out}, 32'd0);

    // Reset while ONE
    ready_in = 1'b0;
    put(1'b1, 1'b1, 1'b1, 5'd14, 32'hCAFEF00D, 32'hE0);
    tick();
    check("rst1_pre_valid", {31'b0, valid_out}, 32'd1);
    rst = 1'b1;
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    check("rst1_valid", {31'b0, valid_out}, 32'd0);
    check("rst1_ready", {31'b0, ready_out}, 32'd1);
    check("rst1_rd", {27'b0, rd_out}, 32'd0);
    check("rst1_wb_data", wb_data_out, 32'd0);
    check("rst1_rdata", read_data_out, 32'd0);
    put(1'b1, 1'b1, 1'b0, 5'd15, 32'h0, 32'h15);
    tick();
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("rst1_new_valid", {31'b0, valid_out}, 32'd1);
    check("rst1_new_rd", {27'b0, rd_out}, 32'd15);
    ready_in = 1'b1;
    tick();
    check("rst1_new_popped", {31'b0, valid_out}, 32'd0);

    // Random handshake against a queue scoreboard
    for (int c = 0; c < 3000; c++) begin
      logic       v, r;
      logic [4:0] rdv;
      logic [31:0] av;
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      rdv = 5'($urandom);
      av  = $urandom;
      ready_in = r;
      put(v, 1'b1, 1'b0, rdv, 32'h0, av);
      check("rnd_valid", {31'b0, valid_out}, {31'b0, (sb_q.size() != 0)});
      check("rnd_ready", {31'b0, ready_out}, {31'b0, (sb_q.size() < 2)});
      if (r && sb_q.size() != 0) begin
        check("rnd_rd", {27'b0, rd_out}, {27'b0, sb_q[0][36:32]});
        check("rnd_addr", address_out, sb_q[0][31:0]);
        void'(sb_q.pop_front());
      end
      if (v && sb_q.size() < 2 && ready_out) sb_q.push_back({rdv, av});
      tick();
    end
    put(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (sb_q.size() != 0) begin
        check("drain_rd", {27'b0, rd_out}, {27'b0, sb_q[0][36:32]});
        check("drain_addr", address_out, sb_q[0][31:0]);
        void'(sb_q.pop_front());
      end
      tick();
    end
    check("drain_empty", {31'b0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
